ddr4_timing_checker: RTL

Synthesizable, parametrised DDR4 command-bus timing checker for the controller/DIMM boundary. It decodes every command on the DDR interface and tracks per-bank open/closed state with per-bank and global elapsed-cycle counters. It flags illegal commands and JEDEC timing violations: tRCD, tRP, tRAS, tRRD, tCCD, tWTR, tRTP, tWR and optionally tREFI. Results are reported as a registered violation event plus sticky status, so the same checks run in simulation, emulation and silicon debug.

---
 rtl/ddr4_timing_checker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ddr4_timing_checker.sv
// rtl/ddr4_timing_checker.sv - DDR4 command-bus legality and timing checker with registered violation reporting.
// Optional tREFI watchdog is compiled in with DDR4_TIMING_CHK_REFI_EN.
module ddr4_timing_checker #(
  parameter int BG_W   = 2,
  parameter int BA_W   = 2,
  parameter int CNT_W  = 8,
  parameter int T_RCD  = 16,
  parameter int T_RP   = 16,
  parameter int T_RAS  = 39,
  parameter int T_RRD  = 4,
  parameter int T_CCD  = 4,
  parameter int T_WTR  = 9,
  parameter int T_RTP  = 9,
  parameter int T_WR   = 18,
  parameter int CWL    = 12,
  parameter int T_REFI = 7800
) (
  input  logic                            i_ck_t,
  input  logic                            i_reset,
  input  logic                            i_cs_n,
  input  logic                            i_act_n,
  input  logic                            i_ras_n_a16,
  input  logic                            i_cas_n_a15,
  input  logic                            i_we_n_a14,
  input  logic                            i_a10,
  input  logic [BG_W-1:0]                 i_bg_addr,
  input  logic [BA_W-1:0]                 i_ba_addr,
  output logic                            o_viol_valid,
  output logic [3:0]                      o_viol_code,
  output logic [BG_W+BA_W-1:0]            o_viol_bank,
  output logic [15:0]                     o_viol_mask,
  output logic [15:0]                     o_viol_count,
  output logic [(2**(BG_W+BA_W))-1:0]     o_bank_open
);
  localparam int BK_W = BG_W + BA_W;
  localparam int NB   = 2**BK_W;
  localparam int TMAX = 2**CNT_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0] TH_RCD = (CNT_W+1)'(T_RCD);
  localparam logic [CNT_W:0] TH_RP  = (CNT_W+1)'(T_RP);
  localparam logic [CNT_W:0] TH_RAS = (CNT_W+1)'(T_RAS);
  localparam logic [CNT_W:0] TH_RRD = (CNT_W+1)'(T_RRD);
  localparam logic [CNT_W:0] TH_CCD = (CNT_W+1)'(T_CCD);
  localparam logic [CNT_W:0] TH_WTR = (CNT_W+1)'(CWL + 4 + T_WTR);
  localparam logic [CNT_W:0] TH_RTP = (CNT_W+1)'(T_RTP);
  localparam logic [CNT_W:0] TH_WR  = (CNT_W+1)'(CWL + 4 + T_WR);

  if (T_RCD < 1 || T_RCD > TMAX || T_RP < 1 || T_RP > TMAX || T_RAS < 1 || T_RAS > TMAX ||
      T_RRD < 1 || T_RRD > TMAX || T_CCD < 1 || T_CCD > TMAX || T_WTR < 1 || T_WTR > TMAX ||
      T_RTP < 1 || T_RTP > TMAX || T_WR < 1 || T_WR > TMAX || CWL < 1 || CWL > TMAX ||
      T_REFI < 1 || T_REFI > 16379) begin : g_param_err
    $error("ddr4_timing_checker: timing parameter out of range");
  end

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_t;

  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  bank_state_t      r_bank_st [NB];
  bank_state_t      w_bank_nx [NB];
  logic [CNT_W-1:0] r_since_act [NB];
  logic [CNT_W-1:0] r_since_pre [NB];
  logic [CNT_W-1:0] r_since_rd [NB];
  logic [CNT_W-1:0] r_since_wr [NB];
  logic [CNT_W-1:0] r_g_act, r_g_cas, r_g_wr;
  logic             r_viol_valid;
  logic [3:0]       r_viol_code;
  logic [BK_W-1:0]  r_viol_bank;
  logic [15:0]      r_viol_mask, r_viol_count;

  logic [BK_W-1:0]  w_bank;
  logic [2:0]       w_op;
  logic             w_cmd, w_act, w_mrs, w_ref, w_pre, w_wr, w_rd, w_zq;
  logic [NB-1:0]    w_open, w_sel, w_pre_tgt, w_p9, w_p10, w_p11, w_pvec;
  logic [12:1]      w_flags;
  logic [3:0]       w_code;
  logic [BK_W-1:0]  w_vbank;
  logic             w_any, w_refi_req;

  assign w_bank = {i_bg_addr, i_ba_addr};
  assign w_op   = {i_ras_n_a16, i_cas_n_a15, i_we_n_a14};
  assign w_cmd  = ~i_cs_n & i_act_n;
  assign w_act  = ~i_cs_n & ~i_act_n;
  assign w_mrs  = w_cmd & (w_op == 3'b000);
  assign w_ref  = w_cmd & (w_op == 3'b001);
  assign w_pre  = w_cmd & (w_op == 3'b010);
  assign w_wr   = w_cmd & (w_op == 3'b100);
  assign w_rd   = w_cmd & (w_op == 3'b101);
  assign w_zq   = w_cmd & (w_op == 3'b110);

  // PRE/PREA only touch banks that are actually open; closed banks see a no-op
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_open[b]    = (r_bank_st[b] == BANK_ACTIVE);
      w_sel[b]     = (w_bank == BK_W'(b));
      w_pre_tgt[b] = w_pre & (i_a10 | w_sel[b]) & w_open[b];
      w_p9[b]      = w_pre_tgt[b] & ({1'b0, r_since_act[b]} < TH_RAS);
      w_p10[b]     = w_pre_tgt[b] & ({1'b0, r_since_rd[b]} < TH_RTP);
      w_p11[b]     = w_pre_tgt[b] & ({1'b0, r_since_wr[b]} < TH_WR);
      w_bank_nx[b] = r_bank_st[b];
      if (w_act & w_sel[b]) w_bank_nx[b] = BANK_ACTIVE;
      else if (w_pre_tgt[b]) w_bank_nx[b] = BANK_IDLE;
    end
  end

  always_comb begin
    w_flags     = '0;
    w_flags[1]  = w_act & w_open[w_bank];
    w_flags[2]  = (w_rd | w_wr) & ~w_open[w_bank];
    w_flags[3]  = (w_ref | w_mrs | w_zq) & (|w_open);
    w_flags[4]  = w_act & ({1'b0, r_since_pre[w_bank]} < TH_RP);
    w_flags[5]  = w_act & ({1'b0, r_g_act} < TH_RRD);
    w_flags[6]  = (w_rd | w_wr) & ({1'b0, r_since_act[w_bank]} < TH_RCD);
    w_flags[7]  = (w_rd | w_wr) & ({1'b0, r_g_cas} < TH_CCD);
    w_flags[8]  = w_rd & ({1'b0, r_g_wr} < TH_WTR);
    w_flags[9]  = |w_p9;
    w_flags[10] = |w_p10;
    w_flags[11] = |w_p11;
    w_flags[12] = w_refi_req;
    w_any       = |w_flags;
    w_code      = '0;
    for (int c = 12; c >= 1; c--) if (w_flags[c]) w_code = 4'(c);
    w_pvec  = (w_code == 4'd9) ? w_p9 : (w_code == 4'd10) ? w_p10 : w_p11;
    w_vbank = (w_code == 4'd12) ? '0 : w_bank;
    if (w_code >= 4'd9 && w_code <= 4'd11)
      for (int b = NB - 1; b >= 0; b--) if (w_pvec[b]) w_vbank = BK_W'(b);
  end

  always_ff @(posedge i_ck_t) begin
    if (i_reset) begin
      for (int b = 0; b < NB; b++) begin
        r_bank_st[b]   <= BANK_IDLE;
        r_since_act[b] <= CNT_MAX;
        r_since_pre[b] <= CNT_MAX;
        r_since_rd[b]  <= CNT_MAX;
        r_since_wr[b]  <= CNT_MAX;
      end
      r_g_act      <= CNT_MAX;
      r_g_cas      <= CNT_MAX;
      r_g_wr       <= CNT_MAX;
      r_viol_valid <= 1'b0;
      r_viol_code  <= '0;
      r_viol_bank  <= '0;
      r_viol_mask  <= '0;
      r_viol_count <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        r_bank_st[b]   <= w_bank_nx[b];
        r_since_act[b] <= (w_act & w_sel[b]) ? CNT_ONE : f_inc(r_since_act[b]);
        r_since_pre[b] <= w_pre_tgt[b] ? CNT_ONE : f_inc(r_since_pre[b]);
        r_since_rd[b]  <= (w_rd & w_sel[b]) ? CNT_ONE : f_inc(r_since_rd[b]);
        r_since_wr[b]  <= (w_wr & w_sel[b]) ? CNT_ONE : f_inc(r_since_wr[b]);
      end
      r_g_act      <= w_act ? CNT_ONE : f_inc(r_g_act);
      r_g_cas      <= (w_rd | w_wr) ? CNT_ONE : f_inc(r_g_cas);
      r_g_wr       <= w_wr ? CNT_ONE : f_inc(r_g_wr);
      r_viol_valid <= w_any;
      r_viol_code  <= w_code;
      r_viol_bank  <= w_vbank;
      if (w_any) begin
        r_viol_mask <= r_viol_mask | (16'd1 << w_code);
        if (r_viol_count != 16'hFFFF) r_viol_count <= r_viol_count + 16'd1;
      end
    end
  end

`ifdef DDR4_TIMING_CHK_REFI_EN
  localparam logic [13:0] REFI_LIM  = 14'(T_REFI + 4);
  localparam logic [13:0] REFI_TRIG = 14'(T_REFI + 3);
  logic [13:0] r_refi_cnt;
  logic        r_refi_pend;

  // A refresh overrun that collides with a command violation is held until a free slot
  assign w_refi_req = r_refi_pend | ((r_refi_cnt == REFI_TRIG) & ~w_ref);

  always_ff @(posedge i_ck_t) begin
    if (i_reset) begin
      r_refi_cnt  <= '0;
      r_refi_pend <= 1'b0;
    end else begin
      if (w_ref) r_refi_cnt <= 14'd1;
      else if (r_refi_cnt != 14'd0 && r_refi_cnt != REFI_LIM) r_refi_cnt <= r_refi_cnt + 14'd1;
      r_refi_pend <= w_refi_req & (|w_flags[11:1]);
    end
  end
`else
  assign w_refi_req = 1'b0;
`endif

  assign o_viol_valid = r_viol_valid;
  assign o_viol_code  = r_viol_code;
  assign o_viol_bank  = r_viol_bank;
  assign o_viol_mask  = r_viol_mask;
  assign o_viol_count = r_viol_count;
  assign o_bank_open  = w_open;
endmodule
